// File: rtl/output_pkg.sv
// Shared types and constants for the output serializer and its chunk mux.
package output_pkg;

  localparam int DATA_W     = 12;                // sample width per axis
  localparam int CHUNK_W    = 2;                 // pad-bus width per axis
  localparam int NCHUNK     = DATA_W / CHUNK_W;  // chunks per sample
  localparam int CNT_W      = $clog2(NCHUNK);    // chunk index width
  localparam int TERM_DEPTH = 7;                 // output terminal pipeline depth

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    SHIFT = 2'd2,
    WAIT  = 2'd3
  } state_t;

endpackage

// File: rtl/ser_chunk_mux.sv
// Combinational selection of one CHUNK_W slice of a sample by chunk index.
// Indices past the last chunk select zero.
module ser_chunk_mux #(
  parameter int DATA_W  = 12,
  parameter int CHUNK_W = 2,
  parameter int IDX_W   = 3
) (
  input  logic [DATA_W-1:0]  i_data,
  input  logic [IDX_W-1:0]   i_idx,
  output logic [CHUNK_W-1:0] o_chunk
);

  localparam int N_SLICES = DATA_W / CHUNK_W;

  logic [CHUNK_W-1:0] w_slices [N_SLICES];

  genvar gi;
  generate
    for (gi = 0; gi < N_SLICES; gi++) begin : g_slice
      assign w_slices[gi] = i_data[gi*CHUNK_W +: CHUNK_W];
    end
  endgenerate

  // Pick the indexed slice, zero when out of range.
  always_comb begin
    o_chunk = '0;
    if (int'(i_idx) < N_SLICES) begin
      o_chunk = w_slices[i_idx];
    end
  end

endmodule

// File: rtl/output_serializer.sv
// Output serializer: latches an X/Y/IS sample from the NCO core and streams
// it to the output terminal LSB-first, CHUNK_W bits per axis per cycle,
// framed by a one-cycle Rdy pulse and closed by the terminal's Vld strobe.
// Optional: define OUTPUT_SERIALIZER_SKID_EN to add a one-entry skid buffer
// so the next sample is taken while a frame is in flight.
module output_serializer
  import output_pkg::*;
#(
  parameter int DATA_W  = output_pkg::DATA_W,
  parameter int CHUNK_W = output_pkg::CHUNK_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [DATA_W-1:0]  Xs,
  input  logic [DATA_W-1:0]  Ys,
  input  logic               ISs,
  input  logic               s_vld,
  output logic               s_rdy,
  output logic               Rdy,
  output logic [CHUNK_W-1:0] Xout,
  output logic [CHUNK_W-1:0] Yout,
  output logic               ISout,
  input  logic               Vld,
  output logic               err
);

  localparam int N_CHUNKS = DATA_W / CHUNK_W;
  localparam int C_W      = (N_CHUNKS > 1) ? $clog2(N_CHUNKS) : 1;

  state_t             r_state, w_state_next;
  logic [C_W-1:0]     r_cnt, w_cnt_next;
  logic [DATA_W-1:0]  r_x, r_y;
  logic               r_is;
  logic               r_rdy;
  logic               r_err;
  logic               r_live;     // low through reset, keeps s_rdy off
  logic               w_hs;
  logic               w_load_in;
  logic               w_load_skid;
  logic               w_err_set;
  logic               w_skid_vld;
  logic [DATA_W-1:0]  w_skid_x, w_skid_y;
  logic               w_skid_is;
  logic [CHUNK_W-1:0] w_x_chunk, w_y_chunk;

  assign w_hs = s_vld && s_rdy;

`ifdef OUTPUT_SERIALIZER_SKID_EN
  logic              r_skid_vld;
  logic [DATA_W-1:0] r_skid_x, r_skid_y;
  logic              r_skid_is;

  // Park a sample accepted mid-frame; release it when the FSM restarts.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_skid_vld <= 1'b0;
      r_skid_x   <= '0;
      r_skid_y   <= '0;
      r_skid_is  <= 1'b0;
    end else if (w_load_skid) begin
      r_skid_vld <= 1'b0;
    end else if (w_hs && !w_load_in) begin
      r_skid_vld <= 1'b1;
      r_skid_x   <= Xs;
      r_skid_y   <= Ys;
      r_skid_is  <= ISs;
    end
  end

  assign s_rdy      = r_live && !r_skid_vld;
  assign w_skid_vld = r_skid_vld;
  assign w_skid_x   = r_skid_x;
  assign w_skid_y   = r_skid_y;
  assign w_skid_is  = r_skid_is;
`else
  assign s_rdy      = r_live && (r_state == IDLE);
  assign w_skid_vld = 1'b0;
  assign w_skid_x   = '0;
  assign w_skid_y   = '0;
  assign w_skid_is  = 1'b0;
`endif

  // Next state: WAIT always lasts one cycle and behaves like IDLE when
  // deciding whether a new frame can start immediately.
  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_load_in    = 1'b0;
    w_load_skid  = 1'b0;
    case (r_state)
      IDLE, WAIT: begin
        w_state_next = IDLE;
        if (w_skid_vld) begin
          w_load_skid  = 1'b1;
          w_state_next = START;
        end else if (w_hs) begin
          w_load_in    = 1'b1;
          w_state_next = START;
        end
      end
      START: begin
        w_state_next = SHIFT;
        w_cnt_next   = '0;
      end
      SHIFT: begin
        if (r_cnt == C_W'(N_CHUNKS - 1)) begin
          w_state_next = WAIT;
        end else begin
          w_cnt_next = r_cnt + C_W'(1);
        end
      end
      default: w_state_next = IDLE;
    endcase
  end

  // Vld is expected exactly in WAIT; anything else is a protocol error.
  assign w_err_set = (r_state == WAIT) ? !Vld : Vld;

  // State, counter, sample latch, frame-start pulse and sticky error.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_x     <= '0;
      r_y     <= '0;
      r_is    <= 1'b0;
      r_rdy   <= 1'b0;
      r_err   <= 1'b0;
      r_live  <= 1'b0;
    end else begin
      r_state <= w_state_next;
      r_cnt   <= w_cnt_next;
      r_rdy   <= (w_state_next == START);
      r_err   <= r_err | w_err_set;
      r_live  <= 1'b1;
      if (w_load_skid) begin
        r_x  <= w_skid_x;
        r_y  <= w_skid_y;
        r_is <= w_skid_is;
      end else if (w_load_in) begin
        r_x  <= Xs;
        r_y  <= Ys;
        r_is <= ISs;
      end
    end
  end

  ser_chunk_mux #(
    .DATA_W  (DATA_W),
    .CHUNK_W (CHUNK_W),
    .IDX_W   (C_W)
  ) u_mux_x (
    .i_data  (r_x),
    .i_idx   (r_cnt),
    .o_chunk (w_x_chunk)
  );

  ser_chunk_mux #(
    .DATA_W  (DATA_W),
    .CHUNK_W (CHUNK_W),
    .IDX_W   (C_W)
  ) u_mux_y (
    .i_data  (r_y),
    .i_idx   (r_cnt),
    .o_chunk (w_y_chunk)
  );

  assign Rdy   = r_rdy;
  assign Xout  = (r_state == SHIFT) ? w_x_chunk : '0;
  assign Yout  = (r_state == SHIFT) ? w_y_chunk : '0;
  assign ISout = r_is && (r_state != IDLE);
  assign err   = r_err;

endmodule

// File: tb/tb_output_serializer.sv
// Directed self-checking bench for output_serializer (default or
// OUTPUT_SERIALIZER_SKID_EN build).
module tb_output_serializer;

`ifdef OUTPUT_SERIALIZER_SKID_EN
  localparam int GAP = 8;
`else
  localparam int GAP = 9;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] Xs, Ys;
  logic        ISs, s_vld, s_rdy, Rdy, ISout, Vld, err;
  logic [1:0]  Xout, Yout;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  output_serializer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .Xs    (Xs),
    .Ys    (Ys),
    .ISs   (ISs),
    .s_vld (s_vld),
    .s_rdy (s_rdy),
    .Rdy   (Rdy),
    .Xout  (Xout),
    .Yout  (Yout),
    .ISout (ISout),
    .Vld   (Vld),
    .err   (err)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full frame from an IDLE cycle; returns the X value rebuilt from chunks.
  task automatic frame(input logic [11:0] x, input logic [11:0] y, input logic is,
                       input logic vld_ok, output logic [11:0] x_asm);
    x_asm = '0;
    Xs = x; Ys = y; ISs = is; s_vld = 1'b1;
    @(negedge clk);
    check("s_rdy_idle", 32'(s_rdy), 32'd1);
    tick();
    s_vld = 1'b0;
    @(negedge clk);
    check("rdy_start", 32'(Rdy), 32'd1);
    check("isout_start", 32'(ISout), 32'(is));
    check("xout_start", 32'(Xout), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge clk);
      check("xout_chunk", 32'(Xout), 32'(x[2*k +: 2]));
      check("yout_chunk", 32'(Yout), 32'(y[2*k +: 2]));
      check("rdy_shift", 32'(Rdy), 32'd0);
      check("isout_shift", 32'(ISout), 32'(is));
      x_asm[2*k +: 2] = Xout;
    end
    tick();
    Vld = vld_ok;
    @(negedge clk);
    check("xout_wait", 32'(Xout), 32'd0);
    check("rdy_wait", 32'(Rdy), 32'd0);
    check("isout_wait", 32'(ISout), 32'(is));
    tick();
    Vld = 1'b0;
    @(negedge clk);
    check("isout_idle", 32'(ISout), 32'd0);
    check("s_rdy_after", 32'(s_rdy), 32'd1);
    $display("frame X=%03h Y=%03h IS=%0d Vld_in_wait=%0d err=%0d", x, y, is, vld_ok, err);
    tick();
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    @(negedge clk);
    check("rst_rdy", 32'(Rdy), 32'd0);
    check("rst_xout", 32'(Xout), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_s_rdy", 32'(s_rdy), 32'd0);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("post_rst_s_rdy", 32'(s_rdy), 32'd1);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    logic [11:0] asm_x, dout;
    logic [11:0] xs [3];
    logic [11:0] ys [3];
    int rdy_cyc [3];
    int n_hs, n_rdy, last_rdy, last_hs;

    rst_n = 1'b0; Xs = '0; Ys = '0; ISs = 1'b0; s_vld = 1'b0; Vld = 1'b0;
    tick();
    @(negedge clk);
    check("rst_isout", 32'(ISout), 32'd0);
    check("rst_yout", 32'(Yout), 32'd0);
    do_reset();

    // Basic frame: X=ABC -> 0,3,3,2,2,2 ; Y=123 -> 3,0,2,0,1,0
    frame(12'hABC, 12'h123, 1'b0, 1'b1, asm_x);
    check("asm_abc", 32'(asm_x), 32'h0ABC);
    check("err_clean1", 32'(err), 32'd0);

    // Chained with a signed terminal: IS=1, X=001 gives -1
    frame(12'h001, 12'h7FE, 1'b1, 1'b1, asm_x);
    dout = ~asm_x + 12'd1;
    check("term_dout", 32'(dout), 32'h0FFF);
    check("err_clean2", 32'(err), 32'd0);

    // Three samples with s_vld held high
    xs[0] = 12'h5A5; xs[1] = 12'h0F0; xs[2] = 12'hC3C;
    ys[0] = 12'h3C3; ys[1] = 12'hF0F; ys[2] = 12'h18E;
    n_hs = 0; n_rdy = 0; last_rdy = -100; last_hs = -100;
    rdy_cyc[0] = 0; rdy_cyc[1] = 0; rdy_cyc[2] = 0;
    Xs = xs[0]; Ys = ys[0]; ISs = 1'b0; s_vld = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      Vld = (cyc == last_rdy + 7);
      @(negedge clk);
      if (Rdy) begin
        if (n_rdy < 3) rdy_cyc[n_rdy] = cyc;
        n_rdy++;
        last_rdy = cyc;
      end
      if (n_rdy > 0 && n_rdy <= 3 && cyc >= last_rdy + 1 && cyc <= last_rdy + 6) begin
        check("burst_x", 32'(Xout), 32'(xs[n_rdy-1][2*(cyc-last_rdy-1) +: 2]));
        check("burst_y", 32'(Yout), 32'(ys[n_rdy-1][2*(cyc-last_rdy-1) +: 2]));
      end
`ifndef OUTPUT_SERIALIZER_SKID_EN
      if (n_hs > 0 && cyc > last_hs && cyc <= last_hs + 8)
        check("s_rdy_busy", 32'(s_rdy), 32'd0);
`endif
      if (s_vld && s_rdy) begin
        n_hs++;
        last_hs = cyc;
      end
      tick();
      if (n_hs >= 3) s_vld = 1'b0;
      else begin
        Xs = xs[n_hs];
        Ys = ys[n_hs];
      end
    end
    Vld = 1'b0;
    $display("burst handshakes=%0d rdy_pulses=%0d at %0d,%0d,%0d", n_hs, n_rdy,
             rdy_cyc[0], rdy_cyc[1], rdy_cyc[2]);
    check("burst_rdy_count", 32'(n_rdy), 32'd3);
    check("burst_gap1", 32'(rdy_cyc[1] - rdy_cyc[0]), 32'(GAP));
    check("burst_gap2", 32'(rdy_cyc[2] - rdy_cyc[1]), 32'(GAP));
    check("burst_err", 32'(err), 32'd0);

    // Missing Vld in WAIT sets a sticky error
    frame(12'h456, 12'h789, 1'b0, 1'b0, asm_x);
    @(negedge clk);
    check("err_no_vld", 32'(err), 32'd1);
    tick(); tick(); tick();
    @(negedge clk);
    check("err_sticky", 32'(err), 32'd1);
    tick();
    do_reset();

    // Vld pulse in IDLE sets the error
    Vld = 1'b1;
    tick();
    Vld = 1'b0;
    @(negedge clk);
    check("err_idle_vld", 32'(err), 32'd1);
    $display("idle Vld pulse err=%0d", err);
    tick();
    do_reset();

    // Reset at SHIFT cycle 3 aborts the frame
    Xs = 12'hFFF; Ys = 12'hFFF; ISs = 1'b1; s_vld = 1'b1;
    tick();
    s_vld = 1'b0;
    tick(); tick(); tick(); tick();
    @(negedge clk);
    check("abort_pre_x", 32'(Xout), 32'd3);
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    check("abort_xout", 32'(Xout), 32'd0);
    check("abort_yout", 32'(Yout), 32'd0);
    check("abort_rdy", 32'(Rdy), 32'd0);
    check("abort_isout", 32'(ISout), 32'd0);
    check("abort_s_rdy", 32'(s_rdy), 32'd0);
    rst_n = 1'b1;
    tick();
    @(negedge clk);
    check("abort_idle_s_rdy", 32'(s_rdy), 32'd1);
    check("abort_no_chunk", 32'(Xout), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    $display("mid-frame reset s_rdy=%0d Xout=%0d", s_rdy, Xout);
    tick();
    Vld = 1'b1;
    tick();
    Vld = 1'b0;
    @(negedge clk);
    check("err_vld_after_rst", 32'(err), 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
